display_scan_mux: RTL and testbench

Time-multiplexed driver for an N-digit 7-segment display bank. It holds a double-buffered snapshot of all digit codes and scans one digit per refresh period. Each step drives the selected digit's code plus an active-low one-hot anode strobe to the downstream hex-to-segment decoder and board pins. It is the parametrised, self-scanning successor to the fixed 8-way combinational digit selector, with a refresh prescaler, per-digit blanking, tear-free updates and a frame-done strobe.

---
 rtl/display_scan_mux_if.sv | 44 ++++
 rtl/display_scan_mux.sv | 137 +++++++++++++
 tb/tb_display_scan_mux.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
// -----------------------------------------------------------------------------
// display_scan_mux_if
//   Bundles the control, data and display signals of display_scan_mux.
//   master : the controller side (drives codes, masks, enable and load).
//   slave  : the scan driver itself (drives the digit strobe and status).
//
//   enable       scan run; low = display dark, scan frozen
//   digits_in    digit codes, digit k at [k*DIGIT_W +: DIGIT_W]
//   digit_en     per-digit enable mask; 0 = digit blanked
//   load         single-cycle snapshot refresh request
//   sel          index of the digit currently driven
//   value_out    snapshot code of digit sel
//   anode_n      active-low one-hot digit strobe; all ones when dark
//   blank        high when anode_n is all ones
//   frame_done   one-cycle pulse after the scan wraps to digit 0
//   load_pending high from an accepted load until the snapshot is taken
// -----------------------------------------------------------------------------
interface display_scan_mux_if #(
    parameter int N_DIGITS = 8,
    parameter int DIGIT_W  = 4
);
    localparam int SEL_W = $clog2(N_DIGITS);

    logic                          enable;
    logic [N_DIGITS*DIGIT_W-1:0]   digits_in;
    logic [N_DIGITS-1:0]           digit_en;
    logic                          load;
    logic [SEL_W-1:0]              sel;
    logic [DIGIT_W-1:0]            value_out;
    logic [N_DIGITS-1:0]           anode_n;
    logic                          blank;
    logic                          frame_done;
    logic                          load_pending;

    modport master (
        output enable, digits_in, digit_en, load,
        input  sel, value_out, anode_n, blank, frame_done, load_pending
    );

    modport slave (
        input  enable, digits_in, digit_en, load,
        output sel, value_out, anode_n, blank, frame_done, load_pending
    );
endinterface

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed driver for an N-digit 7-segment display bank. Keeps a
//   double-buffered snapshot of all digit codes, steps one digit every
//   REFRESH_DIV clocks and drives the selected code together with an
//   active-low one-hot anode strobe. New codes are captured only at the frame
//   boundary so a frame never shows a mix of old and new digits.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    display_scan_mux_if.slave (see the interface file); its
//            N_DIGITS/DIGIT_W must match this module's parameters
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int N_DIGITS    = 8,
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_mux_if.slave   bus
);
    localparam int SEL_W   = $clog2(N_DIGITS);
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int SNAP_W  = N_DIGITS * DIGIT_W;

    localparam logic [SEL_W-1:0]   LAST_SEL  = SEL_W'(N_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0]   r_presc;
    logic [SEL_W-1:0]     r_sel;
    logic [SNAP_W-1:0]    r_snap;
    logic [DIGIT_W-1:0]   r_value;
    logic [N_DIGITS-1:0]  r_anode_n;
    logic                 r_blank;
    logic                 r_frame_done;
    logic                 r_load_pending;

    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_take;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [SNAP_W-1:0]    w_snap_nxt;
    logic [DIGIT_W-1:0]   w_value_nxt;
    logic                 w_digit_on;
    logic [N_DIGITS-1:0]  w_anode_nxt;

    // Next-state view of the scan. The display outputs are computed from the
    // *next* sel and snapshot so they land on the same edge as sel itself;
    // this is what makes digit 0 of a freshly loaded frame show the new code.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // otherwise a path that skips it would infer a latch.
        w_tick      = 1'b0;
        w_wrap      = 1'b0;
        w_take      = 1'b0;
        w_sel_nxt   = r_sel;
        w_snap_nxt  = r_snap;
        w_value_nxt = '0;
        w_digit_on  = 1'b0;
        w_anode_nxt = '1;

        w_tick = bus.enable && (r_presc == PRESC_MAX);
        w_wrap = w_tick && (r_sel == LAST_SEL);
        w_take = w_wrap && (r_load_pending || bus.load);

        if (w_tick) begin
            w_sel_nxt = w_wrap ? '0 : r_sel + 1'b1;
        end

        if (w_take) begin
            w_snap_nxt = bus.digits_in;
        end

        // Explicit compare-and-select keeps unused index codes (non power of
        // two N_DIGITS) from ever addressing outside the snapshot.
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_sel_nxt == SEL_W'(k)) begin
                w_value_nxt = w_snap_nxt[k*DIGIT_W +: DIGIT_W];
                w_digit_on  = bus.enable && bus.digit_en[k];
            end
        end

        if (w_digit_on) begin
            w_anode_nxt = ~(N_DIGITS'(1) << w_sel_nxt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_sel          <= '0;
            // NOTE: the snapshot storage is reset on purpose: a reset must
            // leave the display showing zeros, not stale codes.
            r_snap         <= '0;
            r_value        <= '0;
            r_anode_n      <= '1;
            r_blank        <= 1'b1;
            r_frame_done   <= 1'b0;
            r_load_pending <= 1'b0;
        end else begin
            // Prescaler is parked at 0 while paused so a resumed digit gets a
            // full refresh period.
            if (!bus.enable || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            r_sel        <= w_sel_nxt;
            r_snap       <= w_snap_nxt;
            r_value      <= w_value_nxt;
            r_anode_n    <= w_anode_nxt;
            r_blank      <= ~w_digit_on;
            r_frame_done <= w_wrap;

            // A load on the wrapping cycle is consumed directly; otherwise it
            // is remembered (repeats merge) until the next boundary.
            if (w_wrap) begin
                r_load_pending <= 1'b0;
            end else if (bus.load) begin
                r_load_pending <= 1'b1;
            end
        end
    end

    assign bus.sel          = r_sel;
    assign bus.value_out    = r_value;
    assign bus.anode_n      = r_anode_n;
    assign bus.blank        = r_blank;
    assign bus.frame_done   = r_frame_done;
    assign bus.load_pending = r_load_pending;

endmodule

// File: tb/tb_display_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_display_scan_mux
//   Bench for display_scan_mux with N_DIGITS=8, DIGIT_W=4, REFRESH_DIV=4.
//   The stimulus process queues the expected digit steps and frame pulses;
//   a negedge monitor pops one entry whenever sel changes or frame_done is
//   seen. Level checks at fixed points cover reset, blanking and pausing.
// -----------------------------------------------------------------------------
module tb_display_scan_mux;
    localparam int N_DIGITS    = 8;
    localparam int DIGIT_W     = 4;
    localparam int REFRESH_DIV = 4;

    typedef struct {
        logic [2:0] sel;
        logic [3:0] value;
        logic [7:0] anode_n;
        logic       blank;
    } step_t;

    typedef struct {
        int         gap;
        logic [3:0] value;
    } frame_t;

    logic clk;
    logic rst_n;

    step_t  step_q[$];
    frame_t frame_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b1;
    logic [2:0] last_sel = '0;
    int   last_fd_cyc = 0;

    display_scan_mux_if #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) u_if ();

    display_scan_mux #(
        .N_DIGITS    (N_DIGITS),
        .DIGIT_W     (DIGIT_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_step(input logic [2:0] s, input logic [3:0] v,
                             input logic [7:0] a, input logic b);
        step_t e;
        e.sel = s; e.value = v; e.anode_n = a; e.blank = b;
        step_q.push_back(e);
    endtask

    task automatic push_frame_done(input int gap, input logic [3:0] v);
        frame_t f;
        f.gap = gap; f.value = v;
        frame_q.push_back(f);
    endtask

    // One full frame with every digit enabled: digits 1..7 from snap, then
    // the wrap to digit 0 showing wrap_value.
    task automatic push_frame(input logic [31:0] snap, input logic [3:0] wrap_value);
        logic [7:0] a;
        for (int k = 1; k < 8; k++) begin
            a = ~(8'b1 << k);
            push_step(3'(k), snap[k*4 +: 4], a, 1'b0);
        end
        push_step(3'd0, wrap_value, 8'hFE, 1'b0);
    endtask

    // Monitor: compares each digit step and each frame pulse against the queues.
    always @(negedge clk) begin
        step_t  e;
        frame_t f;
        if (!mon_en) begin
            last_sel    = u_if.sel;
            last_fd_cyc = cyc;
        end else begin
            if (u_if.sel !== last_sel) begin
                if (step_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL step_unexpected: got sel %0d expected no step", u_if.sel);
                end else begin
                    e = step_q.pop_front();
                    check("step_sel",     u_if.sel,       e.sel);
                    check("step_value",   u_if.value_out, e.value);
                    check("step_anode_n", u_if.anode_n,   e.anode_n);
                    check("step_blank",   u_if.blank,     e.blank);
                end
                last_sel = u_if.sel;
            end
            if (u_if.frame_done === 1'b1) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got frame_done 1 expected 0 (t=%0t)", $time);
                end else begin
                    f = frame_q.pop_front();
                    check("frame_sel",   u_if.sel,       0);
                    check("frame_value", u_if.value_out, f.value);
                    if (f.gap != 0) check("frame_period", cyc - last_fd_cyc, f.gap);
                end
                last_fd_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        u_if.enable    = 1'b0;
        u_if.load      = 1'b0;
        u_if.digit_en  = 8'hFF;
        u_if.digits_in = 32'h0;

        // Reset and idle with enable low.
        tick_n(3);
        check("rst_sel",          u_if.sel,          0);
        check("rst_anode_n",      u_if.anode_n,      8'hFF);
        check("rst_blank",        u_if.blank,        1);
        check("rst_value",        u_if.value_out,    0);
        check("rst_frame_done",   u_if.frame_done,   0);
        check("rst_load_pending", u_if.load_pending, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_n(1);
            check("idle_sel",        u_if.sel,        0);
            check("idle_anode_n",    u_if.anode_n,    8'hFF);
            check("idle_frame_done", u_if.frame_done, 0);
        end

        // Scan order: load a snapshot, first frame still shows zeros.
        push_frame(32'h0, 4'h0);
        push_frame_done(0, 4'h0);
        u_if.enable    = 1'b1;
        u_if.load      = 1'b1;
        u_if.digits_in = 32'h76543210;
        tick_n(1);
        u_if.load = 1'b0;
        check("run_anode_n",      u_if.anode_n,      8'hFE);
        check("run_blank",        u_if.blank,        0);
        check("run_load_pending", u_if.load_pending, 1);
        tick_n(30);
        check("pre_wrap_pending", u_if.load_pending, 1);
        tick_n(1);
        check("wrap_pending",     u_if.load_pending, 0);
        check("wrap_frame_done",  u_if.frame_done,   1);

        // Second frame shows 0..7; tear-free reload requested at sel=3.
        push_frame(32'h76543210, 4'hF);
        push_frame_done(32, 4'hF);
        tick_n(13);
        check("tear_sel", u_if.sel, 3);
        u_if.load      = 1'b1;
        u_if.digits_in = 32'h89ABCDEF;
        tick_n(1);
        u_if.load = 1'b0;
        check("tear_pending", u_if.load_pending, 1);
        tick_n(17);
        check("tear_old_value",   u_if.value_out,    7);
        check("tear_pre_pending", u_if.load_pending, 1);
        tick_n(1);
        check("tear_new_value",    u_if.value_out,    4'hF);
        check("tear_post_pending", u_if.load_pending, 0);

        // Third frame: blanking, mid-digit mask change, then enable pause.
        push_step(3'd1, 4'hE, 8'hFF, 1'b1);
        push_step(3'd2, 4'hD, 8'hFB, 1'b0);
        push_step(3'd3, 4'hC, 8'hFF, 1'b1);
        push_step(3'd4, 4'hB, 8'hFF, 1'b1);
        push_step(3'd5, 4'hA, 8'hDF, 1'b0);
        push_step(3'd6, 4'h9, 8'hBF, 1'b0);
        u_if.digit_en = 8'b0000_0101;
        tick_n(9);
        check("mask_sel2",     u_if.sel,     2);
        check("mask_anode_on", u_if.anode_n, 8'hFB);
        u_if.digit_en = 8'b0000_0001;
        tick_n(1);
        check("mask_anode_off", u_if.anode_n, 8'hFF);
        check("mask_blank_off", u_if.blank,   1);
        tick_n(6);
        check("mask_sel4", u_if.sel, 4);
        u_if.digit_en = 8'hFF;
        tick_n(1);
        check("unmask_anode", u_if.anode_n, 8'hEF);
        tick_n(4);
        check("pause_sel_before", u_if.sel,     5);
        check("pause_anode_on",   u_if.anode_n, 8'hDF);
        u_if.enable = 1'b0;
        tick_n(1);
        check("pause_anode_dark", u_if.anode_n, 8'hFF);
        check("pause_blank",      u_if.blank,   1);
        check("pause_sel_hold",   u_if.sel,     5);
        tick_n(9);
        check("pause_sel_end",    u_if.sel,     5);
        check("pause_anode_end",  u_if.anode_n, 8'hFF);
        u_if.enable = 1'b1;
        tick_n(3);
        check("resume_sel",   u_if.sel,     5);
        check("resume_anode", u_if.anode_n, 8'hDF);
        tick_n(1);
        check("resume_step", u_if.sel, 6);

        // Async reset mid-frame with a load pending.
        tick_n(1);
        u_if.load      = 1'b1;
        u_if.digits_in = 32'h0F0F0F0F;
        tick_n(1);
        u_if.load = 1'b0;
        check("arst_pre_pending", u_if.load_pending, 1);
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sel",        u_if.sel,          0);
        check("arst_anode_n",    u_if.anode_n,      8'hFF);
        check("arst_blank",      u_if.blank,        1);
        check("arst_value",      u_if.value_out,    0);
        check("arst_frame_done", u_if.frame_done,   0);
        check("arst_pending",    u_if.load_pending, 0);
        tick_n(2);

        // After reset the snapshot is all zeros for two full frames.
        push_frame(32'h0, 4'h0);
        push_frame_done(0, 4'h0);
        push_frame(32'h0, 4'h0);
        push_frame_done(32, 4'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick_n(66);
        check("post_rst_pending", u_if.load_pending, 0);
        check("steps_left",       step_q.size(),     0);
        check("frames_left",      frame_q.size(),    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
